// File: rtl/vtg_pkg.sv
// Shared timing types and helpers for the video timing generator.
// Default mode is 640x480@60 with active-low syncs.
package vtg_pkg;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vtg_timing_t;

  localparam vtg_timing_t VTG_640x480 = '{
    h_active: 640,
    h_fp:     16,
    h_sync:   96,
    h_bp:     48,
    v_active: 480,
    v_fp:     10,
    v_sync:   2,
    v_bp:     33
  };

  function automatic int unsigned vtg_total(
    input int unsigned active,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Timing bundle between the generator and the pixel source / encoder.
// The master drives timing; the slave drives the run enable.
interface video_timing_gen_if #(
    parameter int unsigned CW = 12
);
    logic          en;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  en,
        output hsync,
        output vsync,
        output de,
        output x,
        output y,
        output line_start,
        output frame_start
    );

    modport slave (
        output en,
        input  hsync,
        input  vsync,
        input  de,
        input  x,
        input  y,
        input  line_start,
        input  frame_start
    );
endinterface

// File: rtl/vtg_axis.sv
// One timing axis: wrapping counter plus region decode of its count.
// Regions run active, front porch, sync, back porch.
module vtg_axis
    import vtg_pkg::*;
#(
    parameter int unsigned ACTIVE = 1,
    parameter int unsigned FP     = 1,
    parameter int unsigned SYNC   = 1,
    parameter int unsigned BP     = 1,
    parameter int unsigned CW     = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          in_active,
    output logic          in_sync
);

    localparam int unsigned TOTAL = vtg_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_HI = CW'(ACTIVE + FP + SYNC);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (step) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

    always_comb begin
        wrap      = step && (count == LAST);
        in_active = count < ACT_END;
        in_sync   = (count >= SYNC_LO) && (count < SYNC_HI);
    end

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-clock timing generator: hsync/vsync/de and raw (x,y) counts,
// all registered one cycle behind the internal counters.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VTG_640x480.h_active,
    parameter int unsigned H_FP       = VTG_640x480.h_fp,
    parameter int unsigned H_SYNC     = VTG_640x480.h_sync,
    parameter int unsigned H_BP       = VTG_640x480.h_bp,
    parameter int unsigned V_ACTIVE   = VTG_640x480.v_active,
    parameter int unsigned V_FP       = VTG_640x480.v_fp,
    parameter int unsigned V_SYNC     = VTG_640x480.v_sync,
    parameter int unsigned V_BP       = VTG_640x480.v_bp,
    parameter bit          H_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter bit          V_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int unsigned CW         = 12
) (
    input logic                clk,
    input logic                rst,
    video_timing_gen_if.master bus
);

    localparam int unsigned H_TOTAL =
        vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL =
        vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam bit CFG_OK =
        (H_ACTIVE >= 1) && (H_FP >= 1) &&
        (H_SYNC >= 1) && (H_BP >= 1) &&
        (V_ACTIVE >= 1) && (V_FP >= 1) &&
        (V_SYNC >= 1) && (V_BP >= 1) &&
        (CW >= 1) && (CW < 32) &&
        (((H_TOTAL - 1) >> CW) == 0) &&
        (((V_TOTAL - 1) >> CW) == 0);

    if (!CFG_OK) begin : g_bad_cfg
        $error("video_timing_gen: invalid timing parameters or CW");
    end

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_act;
    logic          v_act;
    logic          h_syn;
    logic          v_syn;
    logic          v_step;
    logic          at_origin;

    logic          hsync_q;
    logic          vsync_q;
    logic          de_q;
    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;
    logic          ls_q;
    logic          fs_q;

    assign v_step = bus.en && h_wrap;

    vtg_axis #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h (
        .clk       (clk),
        .rst       (rst),
        .step      (bus.en),
        .count     (h_cnt),
        .wrap      (h_wrap),
        .in_active (h_act),
        .in_sync   (h_syn)
    );

    vtg_axis #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v (
        .clk       (clk),
        .rst       (rst),
        .step      (v_step),
        .count     (v_cnt),
        .wrap      (v_wrap),
        .in_active (v_act),
        .in_sync   (v_syn)
    );

    // Tracks counters sitting at (0,0) so frame_start needs no wide compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            at_origin <= 1'b1;
        end else if (bus.en) begin
            at_origin <= v_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q <= ~H_SYNC_POL;
            vsync_q <= ~V_SYNC_POL;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else if (bus.en) begin
            hsync_q <= h_syn ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_q <= v_syn ? V_SYNC_POL : ~V_SYNC_POL;
            de_q    <= h_act && v_act;
            x_q     <= h_cnt;
            y_q     <= v_cnt;
            ls_q    <= (h_cnt == '0) && v_act;
            fs_q    <= at_origin;
        end else begin
            de_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end
    end

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.de          = de_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.line_start  = ls_q;
    assign bus.frame_start = fs_q;

endmodule
